// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the memory-stage state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mdr_mem_unit.sv
// Memory-side datapath stage: MAR/MDR registers plus the RAM read/write
// handshake, reporting completion (ack or timeout abort) back to the sequencer.
module mdr_mem_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  mem_state_t        r_state, w_next_state;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_err;

  logic w_idle, w_wait, w_start_rd, w_start_wr, w_timeout, w_load_ok;
  logic w_unused_bus_hi;

  assign w_idle     = (r_state == IDLE);
  assign w_wait     = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  assign w_start_rd = w_idle && Read;
  assign w_start_wr = w_idle && !Read && Write;
  // Register loads only happen in IDLE when no access starts; an access uses the old MAR.
  assign w_load_ok  = w_idle && !Read && !Write;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  assign w_unused_bus_hi = ^BusMuxOut[DATA_W-1:ADDR_W];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (Read)       w_next_state = RD_WAIT;
        else if (Write) w_next_state = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack || w_timeout) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_mar     <= '0;
      r_mdr     <= '0;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_start_rd || w_start_wr) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= w_start_wr;
        r_err     <= 1'b0;
        r_cnt     <= '0;
      end else if (w_wait) begin
        if (mem_ack) begin
          r_mem_req <= 1'b0;
          if (r_state == RD_WAIT) r_mdr <= mem_rdata;
        end else if (w_timeout) begin
          r_mem_req <= 1'b0;
          r_err     <= 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (w_load_ok && MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
      if (w_load_ok && MDRin) r_mdr <= BusMuxOut;
    end
  end

  assign BusMuxInMDR = r_mdr;
  assign mem_addr    = r_mar;
  assign mem_wdata   = r_mdr;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign err         = r_err;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Directed bench for mdr_mem_unit: loads, zero-wait write, wait-state read,
// collisions, timeout abort and reset during a transaction.
module tb_mdr_mem_unit;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] BusMuxInMDR;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req, mem_we, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  mdr_mem_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(16)) dut (
    .clk        (clk),
    .clear      (clear),
    .BusMuxOut  (BusMuxOut),
    .MARin      (MARin),
    .MDRin      (MDRin),
    .Read       (Read),
    .Write      (Write),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .BusMuxInMDR(BusMuxInMDR),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    clear = 1'b0;
    BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;

    // 1. reset state, then MAR and MDR loads
    tick(); tick();
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_mdr",  BusMuxInMDR,   32'h0);
    check("rst_req",  32'(mem_req),  32'h0);
    check("rst_busy", 32'(busy),     32'h0);
    check("rst_done", 32'(done),     32'h0);
    check("rst_err",  32'(err),      32'h0);
    clear = 1'b1;
    tick();
    BusMuxOut = 32'h1F2; MARin = 1;
    tick();
    MARin = 0; BusMuxOut = 32'hB6; MDRin = 1;
    tick();
    MDRin = 0;
    check("ld_addr", 32'(mem_addr), 32'h1F2);
    check("ld_mdr",  BusMuxInMDR,   32'hB6);
    check("ld_busy", 32'(busy),     32'h0);
    check("ld_done", 32'(done),     32'h0);
    check("ld_err",  32'(err),      32'h0);

    // 2. zero-wait write
    BusMuxOut = 32'h055; MARin = 1;
    tick();
    MARin = 0; BusMuxOut = 32'hDEADBEEF; MDRin = 1;
    tick();
    MDRin = 0; Write = 1;
    tick();
    Write = 0;
    check("wr_req",   32'(mem_req), 32'h1);
    check("wr_we",    32'(mem_we),  32'h1);
    check("wr_wdata", mem_wdata,    32'hDEADBEEF);
    check("wr_addr",  32'(mem_addr), 32'h055);
    check("wr_done0", 32'(done),    32'h0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("wr_req_off", 32'(mem_req), 32'h0);
    check("wr_done",    32'(done),    32'h1);
    check("wr_mdr",     BusMuxInMDR,  32'hDEADBEEF);
    tick();
    check("wr_idle_busy", 32'(busy), 32'h0);
    check("wr_idle_done", 32'(done), 32'h0);

    // 3. read with the ack in the third request cycle
    Read = 1;
    tick();
    Read = 0;
    n_req = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1) n_req++;
      check("rd_we", 32'(mem_we), 32'h0);
      if (i == 2) begin
        mem_ack = 1; mem_rdata = 32'h12345678;
      end
      tick();
    end
    mem_ack = 0; mem_rdata = '0;
    check("rd_req_cycles", 32'(n_req),   32'd3);
    check("rd_done",       32'(done),    32'h1);
    check("rd_mdr",        BusMuxInMDR,  32'h12345678);
    check("rd_req_off",    32'(mem_req), 32'h0);
    tick();
    check("rd_busy_off", 32'(busy), 32'h0);

    // 4. collisions: Read+Write together, loads while busy
    Read = 1; Write = 1;
    tick();
    Read = 0; Write = 0;
    check("col_req",  32'(mem_req), 32'h1);
    check("col_we",   32'(mem_we),  32'h0);
    BusMuxOut = 32'hAAAA; MDRin = 1; MARin = 1;
    tick();
    check("col_mdr_wait", BusMuxInMDR,    32'h12345678);
    check("col_mar_wait", 32'(mem_addr),  32'h055);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("col_done",     32'(done),     32'h1);
    check("col_mdr_done", BusMuxInMDR,   32'hCAFEF00D);
    tick();
    MDRin = 0; MARin = 0;
    check("col_mdr_after", BusMuxInMDR,   32'hCAFEF00D);
    check("col_mar_after", 32'(mem_addr), 32'h055);

    // 5. timeout abort, then a write clears err on acceptance
    Read = 1;
    tick();
    Read = 0;
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      n_req++;
      tick();
    end
    check("to_req_cycles", 32'(n_req),  32'd16);
    check("to_done",       32'(done),   32'h1);
    check("to_err",        32'(err),    32'h1);
    check("to_mdr",        BusMuxInMDR, 32'hCAFEF00D);
    tick();
    check("to_err_sticky", 32'(err),  32'h1);
    check("to_idle",       32'(busy), 32'h0);
    Write = 1;
    tick();
    Write = 0;
    check("to_err_clr", 32'(err),    32'h0);
    check("to_wr_we",   32'(mem_we), 32'h1);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("to_wr_done", 32'(done), 32'h1);
    tick();

    // 6. reset during RD_WAIT, then a stray ack
    Read = 1;
    tick();
    Read = 0;
    check("mid_req", 32'(mem_req), 32'h1);
    #2 clear = 1'b0;
    #1;
    check("mid_req_drop", 32'(mem_req), 32'h0);
    check("mid_busy",     32'(busy),    32'h0);
    check("mid_mdr",      BusMuxInMDR,  32'h0);
    check("mid_addr",     32'(mem_addr), 32'h0);
    #2 clear = 1'b1;
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("stray_done", 32'(done),    32'h0);
    check("stray_mdr",  BusMuxInMDR,  32'h0);
    check("stray_busy", 32'(busy),    32'h0);
    tick();
    check("stray_done2", 32'(done), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdr_mem_unit.md
Name: mdr_mem_unit

Overview:
Memory-side stage that consumes BusMuxOut and produces BusMuxInMDR. It holds the MAR and MDR registers. It runs the read/write handshake with the external RAM and reports completion to the control sequencer, which holds the control step until done. The MDR value feeds the bus through the MDRout path.

Parameters:
DATA_W, 32, width of bus, MDR and memory data
ADDR_W, 9, MAR/memory address width (taken from BusMuxOut[ADDR_W-1:0])
TIMEOUT, 16, max cycles waiting for mem_ack before abort; 0 disables timeout

Ports:
clk  in  1  single system clock, rising edge
clear  in  1  asynchronous, active-low reset
BusMuxOut  in  DATA_W  bus value
MARin  in  1  load MAR from bus
MDRin  in  1  load MDR from bus
Read  in  1  start memory read (level sampled per cycle)
Write  in  1  start memory write
mem_rdata  in  DATA_W  RAM read data, valid when mem_ack=1
mem_ack  in  1  RAM completion, one cycle
BusMuxInMDR  out  DATA_W  MDR contents to bus mux
mem_addr  out  ADDR_W  equals MAR
mem_wdata  out  DATA_W  equals MDR
mem_req  out  1  registered request, held until ack or abort
mem_we  out  1  registered; 1 = write, valid while mem_req=1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on completion (ack or abort)
err  out  1  sticky timeout flag

Behaviour:
- Reset (clear=0, async): MAR=0, MDR=0, state=IDLE, mem_req=0, mem_we=0, done=0, err=0, timeout counter=0. Reset mid-transaction drops mem_req immediately. A late mem_ack after reset is ignored.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, priority Read > Write > loads:
  - Read=1: state->RD_WAIT, mem_req<=1, mem_we<=0, err<=0, counter<=0. MDRin in the same cycle is ignored.
  - Write=1 (Read=0): state->WR_WAIT, mem_req<=1, mem_we<=1, err<=0, counter<=0. mem_wdata = current MDR.
  - MARin and MDRin are honoured in IDLE only when no Read/Write is started that cycle. Both may load in the same cycle.
  - MARin together with Read/Write: MAR is not loaded. The access uses the old MAR. Control must load MAR one step earlier.
- RD_WAIT:
  - mem_ack=1: MDR<=mem_rdata, mem_req<=0, state->DONE.
  - Else counter+1. If TIMEOUT!=0 and counter==TIMEOUT-1: mem_req<=0, err<=1, MDR unchanged, state->DONE.
- WR_WAIT: same as RD_WAIT, but MDR is never modified.
- DONE: done=1 for exactly this cycle, then unconditionally ->IDLE. mem_req=0.
- While busy (RD_WAIT/WR_WAIT/DONE): MARin, MDRin, Read and Write are all ignored. MAR/MDR stay stable, so mem_addr and mem_wdata are constant during the request.
- Latency:
  - Read sampled at edge N. mem_req is high from cycle N+1.
  - Ack in cycle N+k (k>=1) gives MDR valid and done=1 in cycle N+k+1.
  - Zero-wait RAM (ack in first req cycle): 2 cycles from request to done. The next request is accepted in the cycle after done.
- err stays set until clear or the next accepted Read/Write.
- mem_ack outside RD_WAIT/WR_WAIT is ignored.
- Counter width is clog2(TIMEOUT+1). It is saturating and not used when TIMEOUT=0 (the block waits forever).

Decomposition:
- Shared package cpu_pkg: DATA_W/ADDR_W constants and the mem_state_t enum (IDLE, RD_WAIT, WR_WAIT, DONE).
- Single module. The MAR/MDR registers and the FSM stay inline.
- No sub-module: the RAM model lives only in the testbench.

Test Plan:
1. Reset then loads: clear low then high; bus=0x1F2, MARin=1; next cycle bus=0xB6, MDRin=1 -> mem_addr=0x1F2, BusMuxInMDR=0xB6, busy=0, done=0, err=0.
2. Zero-wait write: MAR=0x055, MDR=0xDEADBEEF, Write=1 one cycle; RAM acks immediately -> mem_req=1 and mem_we=1 for 1 cycle with mem_wdata=0xDEADBEEF; done pulses the next cycle; MDR unchanged.
3. Wait-state read: MAR=0x055, Read=1; RAM acks after 3 cycles with 0x12345678 -> mem_req high for 3 cycles, MDR=0x12345678 in the cycle done=1, busy low the cycle after.
4. Collisions: Read and Write together -> read performed, mem_we=0. MDRin=1 with bus=0xAAAA during RD_WAIT -> MDR keeps the read data. MARin during busy -> MAR unchanged.
5. Timeout: TIMEOUT=16, Read with no ack -> mem_req drops after 16 cycles; done=1 and err=1; MDR unchanged. A following Write clears err on acceptance.
6. Reset mid-op: Read issued, clear pulsed low in RD_WAIT -> mem_req=0 immediately, state IDLE, MDR=0. A stray mem_ack afterwards causes no done and no MDR change.
